// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_arb_pkg
// Description : Shared types and constants for the two-requester DDR
//               instruction arbiter (FSM state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

    // Default width of a controller instruction word.
    localparam int c_INST_W_DEFAULT = 12;

    // Arbiter FSM state encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ddr_arb_pick
// Description : Combinational grant selection for the DDR arbiter.
//               A held lock restricts the grant to the current owner;
//               otherwise two contenders alternate (round-robin) and a lone
//               contender always wins.
// Revision    : 1.0 - initial release
// Ports       : valid   [1:0] in  - pending flags of requesters 1/0
//               owner         in  - index of the last-granted requester
//               lock          in  - effective lock (owner keeps ownership)
//               gnt_idx       out - index of the selected requester
//               gnt_vld       out - a requester is selected
// ============================================================================
module ddr_arb_pick
    import ddr_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       owner,
    input  logic       lock,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    always_comb begin
        gnt_idx = owner;
        gnt_vld = 1'b0;
        if (lock) begin
            // Only the owner may proceed; nobody else is considered.
            gnt_idx = owner;
            gnt_vld = valid[owner];
        end else if (valid == 2'b11) begin
            // Both contend: the one that did not win last time goes.
            gnt_idx = ~owner;
            gnt_vld = 1'b1;
        end else if (valid[0]) begin
            gnt_idx = 1'b0;
            gnt_vld = 1'b1;
        end else if (valid[1]) begin
            gnt_idx = 1'b1;
            gnt_vld = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ddr_arb
// Description : Two-requester instruction arbiter in front of a DDR
//               controller. Grants one instruction at a time, strobes it to
//               the controller, then waits for the controller to go busy and
//               idle again (or times out if it never goes busy).
// Revision    : 1.0 - initial release
// Ports       : clk                     in  - rising-edge clock
//               rst_n                   in  - asynchronous active-low reset
//               req{0,1}_inst [INST_W]  in  - requester instruction
//               req{0,1}_valid          in  - requester has work pending
//               req{0,1}_lock           in  - keep ownership after grant
//               req{0,1}_ack            out - one-cycle issue acknowledge
//               ctl_inst [INST_W]       out - instruction to controller
//               ctl_inst_en             out - one-cycle instruction strobe
//               ctl_ready               in  - controller idle / accepting
//               owner                   out - last-granted requester
//               busy                    out - arbiter not idle
// ============================================================================
module ddr_arb
    import ddr_arb_pkg::*;
#(
    parameter int INST_W      = c_INST_W_DEFAULT,
    parameter int ACK_TIMEOUT = 4                   // must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] req0_inst,
    input  logic              req0_valid,
    input  logic              req0_lock,
    output logic              req0_ack,
    input  logic [INST_W-1:0] req1_inst,
    input  logic              req1_valid,
    input  logic              req1_lock,
    output logic              req1_ack,
    output logic [INST_W-1:0] ctl_inst,
    output logic              ctl_inst_en,
    input  logic              ctl_ready,
    output logic              owner,
    output logic              busy
);

    localparam int                 c_CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(ACK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [INST_W-1:0]  ctl_inst_q, ctl_inst_d;
    logic               owner_q, owner_d;
    logic               lock_q, lock_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               inst_en_q, inst_en_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               busy_q, busy_d;

    logic [1:0]         w_valid;
    logic               w_owner_lock;
    logic               w_lock_eff;
    logic               w_gnt_idx;
    logic               w_gnt_vld;

    // The owner dropping its lock while we are idle releases it at once,
    // so the other requester can already win in that same cycle.
    assign w_valid      = {req1_valid, req0_valid};
    assign w_owner_lock = owner_q ? req1_lock : req0_lock;
    assign w_lock_eff   = lock_q & w_owner_lock;

    ddr_arb_pick u_pick (
        .valid   (w_valid),
        .owner   (owner_q),
        .lock    (w_lock_eff),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    always_comb begin
        state_d    = state_q;
        ctl_inst_d = ctl_inst_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                lock_d = w_lock_eff;
                if (ctl_ready && w_gnt_vld) begin
                    state_d    = ST_ISSUE;
                    ctl_inst_d = w_gnt_idx ? req1_inst : req0_inst;
                    owner_d    = w_gnt_idx;
                    lock_d     = w_gnt_idx ? req1_lock : req0_lock;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (cnt_q != c_CNT_MAX) begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
                if (!ctl_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q >= c_CNT_LAST) begin
                    // Controller never went busy (e.g. a NOP): give up.
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (ctl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and acks are flopped from the ISSUE state, so ctl_inst has
        // been stable for a full cycle when the controller sees the strobe,
        // and a reset taken during ISSUE never lets an ack escape.
        inst_en_d = (state_q == ST_ISSUE);
        ack0_d    = inst_en_d & ~owner_q;
        ack1_d    = inst_en_d &  owner_q;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ctl_inst_q <= '0;
            owner_q    <= 1'b1;     // requester 0 wins the first contest
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            inst_en_q  <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctl_inst_q <= ctl_inst_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            inst_en_q  <= inst_en_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign ctl_inst    = ctl_inst_q;
    assign ctl_inst_en = inst_en_q;
    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign owner       = owner_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_arb
// Description : Self-checking bench for ddr_arb. A transaction-level
//               reference model predicts every output each cycle; directed
//               scenarios add fixed-value checks, then randomized requesters
//               and a randomized controller exercise the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_arb;

    localparam int INST_W      = 12;
    localparam int ACK_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [INST_W-1:0] req0_inst = '0;
    logic              req0_valid = 1'b0;
    logic              req0_lock = 1'b0;
    logic              req0_ack;
    logic [INST_W-1:0] req1_inst = '0;
    logic              req1_valid = 1'b0;
    logic              req1_lock = 1'b0;
    logic              req1_ack;
    logic [INST_W-1:0] ctl_inst;
    logic              ctl_inst_en;
    logic              ctl_ready = 1'b1;
    logic              owner;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_arb #(
        .INST_W      (INST_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_inst   (req0_inst),
        .req0_valid  (req0_valid),
        .req0_lock   (req0_lock),
        .req0_ack    (req0_ack),
        .req1_inst   (req1_inst),
        .req1_valid  (req1_valid),
        .req1_lock   (req1_lock),
        .req1_ack    (req1_ack),
        .ctl_inst    (ctl_inst),
        .ctl_inst_en (ctl_inst_en),
        .ctl_ready   (ctl_ready),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: m_since counts cycles since a grant (0 = idle,
    // 1 = issuing), m_wait counts waiting cycles, m_dropped records that
    // the controller has gone busy for this instruction.
    // ------------------------------------------------------------------
    int                m_since;
    int                m_wait;
    bit                m_dropped;
    bit                m_owner;
    bit                m_lock;
    logic [INST_W-1:0] m_inst;
    bit                exp_en, exp_ack0, exp_ack1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_since = 0; m_wait = 0; m_dropped = 0;
        m_owner = 1'b1; m_lock = 1'b0; m_inst = '0;
        exp_en = 0; exp_ack0 = 0; exp_ack1 = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit [1:0] v;
        bit [1:0] lk;
        bit       eff;
        int       w;
        v  = {req1_valid, req0_valid};
        lk = {req1_lock, req0_lock};
        exp_en   = (m_since == 1);
        exp_ack0 = exp_en && !m_owner;
        exp_ack1 = exp_en &&  m_owner;
        if (m_since == 0) begin
            eff    = m_lock && lk[m_owner];
            m_lock = eff;
            w      = -1;
            if (eff) begin
                if (v[m_owner]) w = m_owner ? 1 : 0;
            end else if (v == 2'b11) begin
                w = m_owner ? 0 : 1;
            end else if (v[0]) begin
                w = 0;
            end else if (v[1]) begin
                w = 1;
            end
            if (ctl_ready && w >= 0) begin
                m_since = 1;
                m_owner = (w == 1);
                m_inst  = (w == 1) ? req1_inst : req0_inst;
                m_lock  = lk[w];
            end
        end else if (m_since == 1) begin
            m_since = 2; m_wait = 1; m_dropped = 0;
        end else if (m_dropped) begin
            if (ctl_ready) m_since = 0;
        end else if (!ctl_ready) begin
            m_dropped = 1;
        end else if (m_wait >= ACK_TIMEOUT) begin
            m_since = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic compare_all();
        chk("en",    {31'd0, ctl_inst_en}, {31'd0, exp_en});
        chk("ack0",  {31'd0, req0_ack},    {31'd0, exp_ack0});
        chk("ack1",  {31'd0, req1_ack},    {31'd0, exp_ack1});
        chk("owner", {31'd0, owner},       {31'd0, m_owner});
        chk("busy",  {31'd0, busy},        {31'd0, (m_since != 0)});
        chk("inst",  32'(ctl_inst),        32'(m_inst));
    endtask

    // One clock: model step, clock edge, compare on the falling edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_strobe(input string tag, input int max_cyc);
        bit found;
        found = 0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            cyc();
            if (ctl_inst_en === 1'b1) found = 1;
        end
        chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic drain();
        req0_valid = 0; req1_valid = 0; req0_lock = 0; req1_lock = 0;
        ctl_ready  = 1;
        for (int i = 0; i < 20 && m_since != 0; i++) cyc();
        cyc();
    endtask

    task automatic rand_req(inout logic v, inout logic [INST_W-1:0] ins,
                            inout logic lk, input bit acked);
        if (acked) begin
            v   = ($urandom_range(0, 1) == 1);
            ins = INST_W'($urandom);
            lk  = ($urandom_range(0, 3) == 0);
        end else if (!v) begin
            if ($urandom_range(0, 3) == 0) begin
                v   = 1;
                ins = INST_W'($urandom);
                lk  = ($urandom_range(0, 3) == 0);
            end
        end else if ($urandom_range(0, 31) == 0) begin
            v = 0;      // withdrawal before ack
        end
        if ($urandom_range(0, 15) == 0) lk = ~lk;
    endtask

    int ctl_hold;

    initial begin
        model_reset();
        #2 rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_en",    {31'd0, ctl_inst_en}, 32'd0);
        chk("rst_ack0",  {31'd0, req0_ack},    32'd0);
        chk("rst_ack1",  {31'd0, req1_ack},    32'd0);
        chk("rst_owner", {31'd0, owner},       32'd1);
        chk("rst_busy",  {31'd0, busy},        32'd0);
        chk("rst_inst",  32'(ctl_inst),        32'd0);
        rst_n = 1;

        // Both requesters at once: req0 first, req1 after the controller
        // has been busy for three cycles.
        req0_valid = 1; req0_inst = 12'h111;
        req1_valid = 1; req1_inst = 12'h222;
        ctl_ready  = 1;
        cyc();
        chk("r31_owner0", {31'd0, owner}, 32'd0);
        chk("r31_inst0",  32'(ctl_inst),  32'h111);
        cyc();
        chk("r31_en0",   {31'd0, ctl_inst_en}, 32'd1);
        chk("r31_ack0",  {31'd0, req0_ack},    32'd1);
        req0_valid = 0; ctl_ready = 0;
        cyc(); cyc(); cyc();
        ctl_ready = 1;
        cyc(); cyc(); cyc();
        chk("r31_en1",    {31'd0, ctl_inst_en}, 32'd1);
        chk("r31_ack1",   {31'd0, req1_ack},    32'd1);
        chk("r31_owner1", {31'd0, owner},       32'd1);
        chk("r31_inst1",  32'(ctl_inst),        32'h222);
        req1_valid = 0;

        // Locked requester 1 keeps req0 out until it releases the lock.
        drain();
        req1_valid = 1; req1_inst = 12'h0A5; req1_lock = 1;
        run_until_strobe("r32_a5", 10);
        chk("r32_a5_inst", 32'(ctl_inst), 32'h0A5);
        chk("r32_a5_ack1", {31'd0, req1_ack}, 32'd1);
        req1_valid = 0; req1_inst = 12'h0A6;
        req0_valid = 1; req0_inst = 12'h0B0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("r32_locked_en", {31'd0, ctl_inst_en}, 32'd0);
        end
        req1_valid = 1;
        run_until_strobe("r32_a6", 12);
        chk("r32_a6_inst", 32'(ctl_inst), 32'h0A6);
        chk("r32_a6_ack1", {31'd0, req1_ack}, 32'd1);
        chk("r32_a6_ack0", {31'd0, req0_ack}, 32'd0);
        req1_valid = 0; req1_lock = 0;
        run_until_strobe("r32_b0", 12);
        chk("r32_b0_ack0",  {31'd0, req0_ack}, 32'd1);
        chk("r32_b0_inst",  32'(ctl_inst),     32'h0B0);
        chk("r32_b0_owner", {31'd0, owner},    32'd0);
        req0_valid = 0;

        // NOP: controller never goes busy, arbiter times out.
        drain();
        req0_valid = 1; req0_inst = 12'h000;
        run_until_strobe("r33", 10);
        req0_valid = 0;
        chk("r33_busy_strobe", {31'd0, busy}, 32'd1);
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
            cyc();
            chk("r33_busy_wait", {31'd0, busy}, 32'd1);
        end
        cyc();
        chk("r33_idle", {31'd0, busy}, 32'd0);

        // Controller not ready when the request arrives.
        drain();
        ctl_ready = 0;
        req1_valid = 1; req1_inst = 12'h345;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("r34_hold_en", {31'd0, ctl_inst_en}, 32'd0);
        end
        ctl_ready = 1;
        cyc();
        chk("r34_lat1", {31'd0, ctl_inst_en}, 32'd0);
        cyc();
        chk("r34_lat2", {31'd0, ctl_inst_en}, 32'd1);
        chk("r34_ack1", {31'd0, req1_ack},    32'd1);

        // One-cycle valid pulse while the controller is busy is ignored.
        req1_valid = 0; ctl_ready = 0;
        cyc(); cyc();
        req0_valid = 1; req0_inst = 12'h0EE;
        cyc();
        req0_valid = 0;
        cyc();
        ctl_ready = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("r36_no_en",  {31'd0, ctl_inst_en}, 32'd0);
            chk("r36_no_ack", {31'd0, req0_ack},    32'd0);
        end

        // Reset taken in the ISSUE cycle: no strobe, no ack.
        drain();
        req0_valid = 1; req0_inst = 12'hFFF;
        cyc();
        chk("r35_inst_pre", 32'(ctl_inst), 32'hFFF);
        rst_n = 0;
        #1;
        chk("r35_en",    {31'd0, ctl_inst_en}, 32'd0);
        chk("r35_inst",  32'(ctl_inst),        32'd0);
        chk("r35_owner", {31'd0, owner},       32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("r35_no_ack", {31'd0, req0_ack},    32'd0);
        chk("r35_no_en",  {31'd0, ctl_inst_en}, 32'd0);
        req0_valid = 0;
        model_reset();
        rst_n = 1;

        // Reset taken while the strobe is visible drops it immediately.
        req0_valid = 1;
        cyc(); cyc();
        chk("r35b_en_pre", {31'd0, ctl_inst_en}, 32'd1);
        rst_n = 0;
        #1;
        chk("r35b_en",   {31'd0, ctl_inst_en}, 32'd0);
        chk("r35b_ack0", {31'd0, req0_ack},    32'd0);
        chk("r35b_inst", 32'(ctl_inst),        32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        model_reset();
        rst_n = 1;

        // Randomized traffic against the model.
        ctl_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            rand_req(req0_valid, req0_inst, req0_lock, exp_ack0);
            rand_req(req1_valid, req1_inst, req1_lock, exp_ack1);
            if (exp_en) ctl_hold = $urandom_range(0, 3);
            else if (ctl_hold > 0) ctl_hold--;
            ctl_ready = (ctl_hold == 0) ? ($urandom_range(0, 7) != 0) : 1'b0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
